// File: rtl/renkon_pool.sv
// 2x2 stride-2 signed max pooling over a raster pixel stream, with a half-width line buffer.
// Optional macro RENKON_POOL_BYPASS_EN adds the pool_bypass input for unpooled pass-through.
module renkon_pool #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned MAXW   = 256,
  parameter int unsigned LWIDTH = 9
) (
  input  logic                     clk,
  input  logic                     xrst,
`ifdef RENKON_POOL_BYPASS_EN
  input  logic                     pool_bypass,
`endif
  input  logic                     frame_start,
  input  logic [LWIDTH-1:0]        img_w,
  input  logic [LWIDTH-1:0]        img_h,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] pixel_in,
  output logic                     out_valid,
  output logic signed [DWIDTH-1:0] pixel_out,
  output logic                     frame_done
);

  localparam int unsigned LB_DEPTH = MAXW / 2;
  localparam int unsigned AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [LWIDTH-1:0]        r_col, r_row;
  logic signed [DWIDTH-1:0] r_h;
  logic                     r_out_valid, r_frame_done;
  logic signed [DWIDTH-1:0] r_pixel_out;
  logic signed [DWIDTH-1:0] r_linebuf [LB_DEPTH];

  logic [LWIDTH-1:0]        w_col_cur, w_row_cur, w_col_nxt, w_row_nxt;
  logic [LWIDTH-1:0]        w_pcol_last, w_prow_last;
  logic signed [DWIDTH-1:0] w_h_cur, w_h_nxt, w_hmax, w_lb_rd, w_pool, w_po_nxt;
  logic                     w_last_col, w_last_row, w_ov_nxt, w_fd_nxt, w_lb_we, w_bypass;
  logic [AW-1:0]            w_lb_addr;

`ifdef RENKON_POOL_BYPASS_EN
  assign w_bypass = pool_bypass;
`else
  assign w_bypass = 1'b0;
`endif

  // frame_start restarts the position first, so a coincident pixel lands at (0,0)
  always_comb begin
    w_col_cur   = frame_start ? '0 : r_col;
    w_row_cur   = frame_start ? '0 : r_row;
    w_h_cur     = frame_start ? '0 : r_h;
    w_last_col  = (w_col_cur == img_w - LWIDTH'(1));
    w_last_row  = (w_row_cur == img_h - LWIDTH'(1));
    w_pcol_last = {img_w[LWIDTH-1:1], 1'b0} - LWIDTH'(1);
    w_prow_last = {img_h[LWIDTH-1:1], 1'b0} - LWIDTH'(1);
    w_lb_addr   = w_col_cur[AW:1];
    w_lb_rd     = r_linebuf[w_lb_addr];
    w_hmax      = (pixel_in > w_h_cur) ? pixel_in : w_h_cur;
    w_pool      = (w_hmax > w_lb_rd) ? w_hmax : w_lb_rd;

    w_col_nxt   = w_col_cur;
    w_row_nxt   = w_row_cur;
    w_h_nxt     = w_h_cur;
    w_ov_nxt    = 1'b0;
    w_fd_nxt    = 1'b0;
    w_po_nxt    = r_pixel_out;
    w_lb_we     = 1'b0;

    if (in_valid) begin
      if (w_last_col) begin
        w_col_nxt = '0;
        w_row_nxt = w_last_row ? '0 : w_row_cur + LWIDTH'(1);
      end else begin
        w_col_nxt = w_col_cur + LWIDTH'(1);
      end

      if (w_bypass) begin
        w_ov_nxt = 1'b1;
        w_po_nxt = pixel_in;
        w_fd_nxt = w_last_col && w_last_row;
      end else if (!w_col_cur[0]) begin
        w_h_nxt = pixel_in;
      end else if (!w_row_cur[0]) begin
        w_lb_we = 1'b1;
      end else begin
        // odd rows of an odd-height frame never reach here: the last row index is even
        w_ov_nxt = 1'b1;
        w_po_nxt = w_pool;
        w_fd_nxt = (w_col_cur == w_pcol_last) && (w_row_cur == w_prow_last);
      end
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_h          <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_pixel_out  <= '0;
    end else begin
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_h          <= w_h_nxt;
      r_out_valid  <= w_ov_nxt;
      r_frame_done <= w_fd_nxt;
      r_pixel_out  <= w_po_nxt;
    end
  end

  // Entries are always written on an even row before the odd row reads them
  always_ff @(posedge clk) begin
    if (w_lb_we) r_linebuf[w_lb_addr] <= w_hmax;
  end

  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign pixel_out  = r_pixel_out;

endmodule

// File: tb/tb_renkon_pool.sv
// Self-checking bench for renkon_pool: table of pixels with expected outputs feeding a scoreboard.
module tb_renkon_pool;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 9;

  logic                 clk = 1'b0;
  logic                 xrst = 1'b1;
  logic                 frame_start = 1'b0;
  logic [LW-1:0]        img_w = LW'(2);
  logic [LW-1:0]        img_h = LW'(2);
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] pixel_in = '0;
  logic                 out_valid, frame_done;
  logic signed [DW-1:0] pixel_out;
`ifdef RENKON_POOL_BYPASS_EN
  logic                 pool_bypass = 1'b0;
`endif

  renkon_pool #(.DWIDTH(DW), .MAXW(256), .LWIDTH(LW)) dut (
    .clk(clk), .xrst(xrst),
`ifdef RENKON_POOL_BYPASS_EN
    .pool_bypass(pool_bypass),
`endif
    .frame_start(frame_start), .img_w(img_w), .img_h(img_h),
    .in_valid(in_valid), .pixel_in(pixel_in),
    .out_valid(out_valid), .pixel_out(pixel_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 fs;
    logic [3:0]           gap;
    logic [LW-1:0]        w;
    logic [LW-1:0]        h;
    logic signed [DW-1:0] pix;
    logic                 ev;
    logic signed [DW-1:0] ep;
    logic                 ef;
  } vec_t;

  typedef struct {
    logic signed [DW-1:0] pix;
    logic                 fd;
    int                   cyc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done = 1'b0;
  logic signed [DW-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(input bit fs, input int gap, input int w, input int h,
                     input int pix, input bit ev, input int ep, input bit ef);
    vec_t v;
    v.fs = fs; v.gap = 4'(gap); v.w = LW'(w); v.h = LW'(h);
    v.pix = DW'(pix); v.ev = ev; v.ep = DW'(ep); v.ef = ef;
    tbl.push_back(v);
  endtask

  task automatic step(input logic fs, input logic v, input logic signed [DW-1:0] p,
                      input logic [LW-1:0] w, input logic [LW-1:0] h);
    @(posedge clk);
    #1;
    frame_start = fs; in_valid = v; pixel_in = p; img_w = w; img_h = h;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, img_w, img_h);
  endtask

  task automatic expect_out(input logic signed [DW-1:0] p, input logic fd);
    exp_t e;
    e.pix = p; e.fd = fd; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // Output monitor and scoreboard; also owns the final summary
  always @(negedge clk) begin
    if (done) begin
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL drain: %0d outputs still pending, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end else if (xrst) begin
      last_exp = '0;
      n_cmp++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || pixel_out !== '0) begin
        n_bad++;
        $display("FAIL reset: ov=%b fd=%b px=%0d required 0/0/0", out_valid, frame_done, pixel_out);
      end
    end else if (out_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: px=%0d at cycle %0d, required no output", pixel_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_exp = e.pix;
        if (pixel_out !== e.pix) begin
          n_bad++;
          $display("FAIL pixel: got %0d required %0d", pixel_out, e.pix);
        end
        n_cmp++;
        if (frame_done !== e.fd) begin
          n_bad++;
          $display("FAIL frame_done: got %b required %b (px %0d)", frame_done, e.fd, e.pix);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_bad++;
          $display("FAIL latency: output at cycle %0d required cycle %0d", cyc, e.cyc);
        end
      end
    end else begin
      n_cmp++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || pixel_out !== last_exp) begin
        n_bad++;
        $display("FAIL idle_hold: ov=%b fd=%b px=%0d required 0/0/%0d",
                 out_valid, frame_done, pixel_out, last_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int img[5][7];
    // 4x2 back-to-back
    add(1,0,4,2, 1,0,0,0); add(0,0,4,2, 5,0,0,0); add(0,0,4,2, 2,0,0,0); add(0,0,4,2, 3,0,0,0);
    add(0,0,4,2, 4,0,0,0); add(0,0,4,2, 0,1,5,0); add(0,0,4,2, 7,0,0,0); add(0,0,4,2, 6,1,7,1);
    // 2x2 all negative, then frame_start with first pixel of next frame
    add(1,0,2,2,-3,0,0,0); add(0,0,2,2,-8,0,0,0); add(0,0,2,2,-1,0,0,0); add(0,0,2,2,-5,1,-1,1);
    add(1,0,2,2,10,0,0,0); add(0,0,2,2,20,0,0,0); add(0,0,2,2,30,0,0,0); add(0,0,2,2,40,1,40,1);
    // 5x3 ramp with in_valid every other cycle; odd column and row discarded
    for (int i = 0; i < 15; i++)
      add(i == 0, 1, 5, 3, i, (i == 6) || (i == 8), i, i == 8);
    // next frame with no frame_start relies on counters wrapping
    add(0,0,4,2,-1,0,0,0); add(0,0,4,2,-2,0,0,0); add(0,0,4,2, 3,0,0,0); add(0,0,4,2,-4,0,0,0);
    add(0,0,4,2, 5,0,0,0); add(0,0,4,2,-6,1,5,0); add(0,0,4,2,-7,0,0,0); add(0,0,4,2,-8,1,3,1);
    // equal operands
    add(1,0,2,2, 7,0,0,0); add(0,0,2,2, 7,0,0,0); add(0,0,2,2, 7,0,0,0); add(0,0,2,2, 7,1,7,1);

    repeat (3) @(posedge clk);
    #1 xrst = 1'b0;
    idle();

    foreach (tbl[i]) begin
      repeat (tbl[i].gap) idle();
      step(tbl[i].fs, 1'b1, tbl[i].pix, tbl[i].w, tbl[i].h);
      if (tbl[i].ev) expect_out(tbl[i].ep, tbl[i].ef);
    end
    repeat (3) idle();

    // Reset mid-frame, then a full frame from position (0,0)
    step(1'b1, 1'b1, 16'sd50, 9'd4, 9'd2);
    step(1'b0, 1'b1, 16'sd60, 9'd4, 9'd2);
    step(1'b0, 1'b1, 16'sd70, 9'd4, 9'd2);
    idle();
    #2 xrst = 1'b1;
    repeat (2) @(posedge clk);
    #1 xrst = 1'b0;
    begin
      int rp[8] = '{9, 1, 1, 1, 1, 1, 1, 2};
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, DW'(rp[i]), 9'd4, 9'd2);
        if (i == 5) expect_out(16'sd9, 1'b0);
        if (i == 7) expect_out(16'sd2, 1'b1);
      end
    end
    repeat (3) idle();

    // Random 7x5 frame with random gaps against a reference pool
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 7; c++)
        img[r][c] = int'($urandom_range(0, 200)) - 100;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 7; c++) begin
        repeat ($urandom_range(0, 2)) idle();
        step(r == 0 && c == 0, 1'b1, DW'(img[r][c]), 9'd7, 9'd5);
        if (r[0] && c[0] && r < 4 && c < 6) begin
          int m;
          m = img[r-1][c-1];
          if (img[r-1][c] > m) m = img[r-1][c];
          if (img[r][c-1] > m) m = img[r][c-1];
          if (img[r][c] > m) m = img[r][c];
          expect_out(DW'(m), (r == 3) && (c == 5));
        end
      end
    end
    repeat (3) idle();

`ifdef RENKON_POOL_BYPASS_EN
    pool_bypass = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 1'b1, DW'(3 + i), 9'd2, 9'd2);
      expect_out(DW'(3 + i), i == 3);
    end
    repeat (2) idle();
    pool_bypass = 1'b0;
`endif

    repeat (2) idle();
    done = 1'b1;
  end

endmodule

// File: doc/renkon_pool.md
RENKON_POOL -- requirements
Module: renkon_pool

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, pixel width in bits (signed two's complement).
REQ-002 SHALL have parameter MAXW, default 256, maximum input image width in pixels (even).
REQ-003 SHALL have parameter LWIDTH, default 9, width of the img_w, img_h and internal row/column counters.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 xrst  in  1  reset, asynchronous, active-high (xrst=1 resets).
REQ-006 frame_start  in  1  single-cycle pulse; begins a new frame.
REQ-007 img_w  in  LWIDTH  input image width in pixels, 2..MAXW; stable for the whole frame.
REQ-008 img_h  in  LWIDTH  input image height in rows, >=2; stable for the whole frame.
REQ-009 in_valid  in  1  pixel_in valid this cycle; raster order, row-major.
REQ-010 pixel_in  in  DWIDTH signed  rectified pixel from the upstream ReLU stage.
REQ-011 out_valid  out  1  pixel_out valid this cycle.
REQ-012 pixel_out  out  DWIDTH signed  2x2 max-pooled pixel.
REQ-013 frame_done  out  1  single-cycle pulse coincident with the last pooled output of a frame.

Function
REQ-014 SHALL perform 2x2 max pooling, stride 2, with output size floor(img_w/2) x floor(img_h/2).
REQ-015 SHALL track the input position with column counter col (0..img_w-1, wraps to 0) and row counter row, both advancing only on in_valid.
REQ-016 On an even col, SHALL hold pixel_in in a horizontal register h.
REQ-017 On an odd col, SHALL form hmax = signed max(h, pixel_in).
REQ-018 On an even row with odd col, SHALL write hmax to line buffer entry col>>1; line buffer depth is MAXW/2 entries of DWIDTH bits.
REQ-019 On an odd row with odd col, SHALL compute signed max(hmax, linebuf[col>>1]) and present it on pixel_out with out_valid=1 exactly one cycle after the accepting edge.
REQ-020 out_valid SHALL be high for one cycle per pooled pixel; pixel_out SHALL hold its last value while out_valid=0.
REQ-021 If img_w is odd, the final column of each row SHALL be consumed and discarded; if img_h is odd, the final row SHALL be consumed and discarded, with no output.
REQ-022 frame_done SHALL assert together with out_valid for the output at pooled position (floor(img_h/2)-1, floor(img_w/2)-1).
REQ-023 After the last input pixel of a frame (row img_h-1, col img_w-1), counters SHALL return to 0; further in_valid pixels start a new frame.
REQ-024 frame_start SHALL clear col, row and h synchronously and SHALL take priority; a pixel with in_valid in the same cycle SHALL be accepted as position (0,0).
REQ-025 frame_start SHALL NOT cancel a pooled output already registered on the preceding edge.
REQ-026 Gaps (in_valid=0) of any length SHALL be tolerated with no change of state.
REQ-027 Equal operands SHALL yield that value; negative inputs SHALL be compared as signed.

Reset
REQ-028 While xrst=1, out_valid=0, frame_done=0, pixel_out=0, col=0, row=0, h=0, asynchronously.
REQ-029 Line buffer contents SHALL NOT require reset; no output SHALL depend on an entry not written in the current frame.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first pixel after release is position (0,0).

Configuration
REQ-031 With macro RENKON_POOL_BYPASS_EN defined, SHALL add input pool_bypass (1 bit); when it is 1, each in_valid pixel SHALL appear on pixel_out with out_valid=1 one cycle later, unpooled; frame_done SHALL pulse with output of position (img_h-1, img_w-1).
REQ-032 Without RENKON_POOL_BYPASS_EN, port pool_bypass SHALL NOT exist and pooling SHALL always be active.

Verification
REQ-033 img_w=4, img_h=2, inputs 1,5,2,3 / 4,0,7,6 back-to-back -> outputs 5 then 7, frame_done with 7.
REQ-034 img_w=2, img_h=2, inputs -3,-8,-1,-5 -> single output -1, frame_done=1.
REQ-035 img_w=5, img_h=3, ramp 0..14 with in_valid toggling every other cycle -> outputs 6, 8 only; frame_done with 8.
REQ-036 Assert xrst after 3 pixels of a 4x2 frame, release, send full frame 9,1,1,1 / 1,1,1,2 -> outputs 9, 2 only.
REQ-037 frame_start coincident with first pixel of 2x2 frame 10,20,30,40 immediately after a completed frame -> output 40, previous output not lost.
REQ-038 With RENKON_POOL_BYPASS_EN and pool_bypass=1, img_w=2, img_h=2, inputs 3,4,5,6 -> outputs 3,4,5,6 each one cycle later, frame_done with 6.
